mul_seq_unit: RTL and testbench

Iterative shift-add multiplier sitting directly downstream of the single-cycle controller: it consumes the decoded multiply request (IsMul, qualified by the condition check) together with the register-file operands, and produces a 32- or 64-bit product for the write-back path. While a multiply is in flight, it stalls the datapath so that PC and register writes hold. It supports MUL, UMULL and SMULL, and produces N/Z flags for the S-suffixed forms.

---
 rtl/mul_seq_unit_if.sv | 27 ++
 rtl/mul_seq_unit.sv | 112 +++++++++++
 tb/tb_mul_seq_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mul_seq_unit_if.sv
// Multiply request/response bundle between the controller datapath and the
// iterative multiplier; slave is the multiplier side.
interface mul_seq_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic             Signed;
   logic             Long;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             Stall;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] ResultLo;
   logic [WIDTH-1:0] ResultHi;
   logic [1:0]       MulFlags;

   modport master (
      output Start, Signed, Long, SrcA, SrcB,
      input  Stall, Busy, Done, ResultLo, ResultHi, MulFlags
   );

   modport slave (
      input  Start, Signed, Long, SrcA, SrcB,
      output Stall, Busy, Done, ResultLo, ResultHi, MulFlags
   );
endinterface

// File: rtl/mul_seq_unit.sv
// Iterative shift-add multiplier (MUL/UMULL/SMULL) with fixed WIDTH+2 latency.
// Signed forms multiply magnitudes and fix the sign in a final FIX cycle.
module mul_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   mul_seq_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             r_state;
   logic               r_long;
   logic               r_neg;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH:0]   r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi;
   logic [1:0]         r_flags;

   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic [WIDTH:0]     w_upper;
   logic [2*WIDTH:0]   w_acc_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res_lo;
   logic [WIDTH-1:0]   w_res_hi;
   logic               w_n;
   logic               w_z;
   logic               w_last;

   // 0x80000000 negates to itself, which is exactly its unsigned magnitude
   assign w_a_abs = (bus.Signed && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
   assign w_b_abs = (bus.Signed && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;

   assign w_upper   = r_acc[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : '0);
   assign w_acc_nxt = {1'b0, w_upper, r_acc[WIDTH-1:1]};
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   assign w_prod   = r_neg ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
   assign w_res_lo = w_prod[WIDTH-1:0];
   assign w_res_hi = r_long ? w_prod[2*WIDTH-1:WIDTH] : '0;
   assign w_n      = r_long ? w_prod[2*WIDTH-1] : w_prod[WIDTH-1];
   assign w_z      = r_long ? (w_prod == '0) : (w_res_lo == '0);

   // Combinational IDLE term lets the very first Start cycle hold the PC
   assign bus.Stall    = reset & (((r_state == IDLE) & bus.Start) | r_busy);
   assign bus.Busy     = r_busy;
   assign bus.Done     = r_done;
   assign bus.ResultLo = r_lo;
   assign bus.ResultHi = r_hi;
   assign bus.MulFlags = r_flags;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_long   <= 1'b0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_lo     <= '0;
         r_hi     <= '0;
         r_flags  <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.Start) begin
                  r_long   <= bus.Long;
                  r_neg    <= bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
                  r_mcand  <= w_a_abs;
                  r_mplier <= w_b_abs;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_acc    <= w_acc_nxt;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) r_state <= FIX;
            end
            FIX: begin
               r_lo    <= w_res_lo;
               r_hi    <= w_res_hi;
               r_flags <= {w_n, w_z};
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= DONE;
            end
            DONE: begin
               // Start is still high here for the retiring instruction
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_seq_unit.sv
// Scoreboard bench for mul_seq_unit: directed multiplies push expected results,
// a monitor pops and compares on every Done pulse.
module tb_mul_seq_unit;
   localparam int W   = 32;
   localparam int LAT = W + 2;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [1:0]   fl;
      int           cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;
   exp_t sb[$];

   mul_seq_unit_if #(.WIDTH(W)) ifc ();

   mul_seq_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at posedge+#1; returns at posedge+#1 of the cycle after DONE.
   task automatic mul(input bit sg, input bit lg, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic [1:0] ef,
                      input bit perturb, input bit keep);
      exp_t e;
      bit   stall_ok;
      bit   got;
      e.lo = elo; e.hi = ehi; e.fl = ef; e.cyc = cyc;
      sb.push_back(e);
      ifc.Start = 1'b1; ifc.Signed = sg; ifc.Long = lg; ifc.SrcA = a; ifc.SrcB = b;
      stall_ok = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ifc.Done === 1'b1) begin
            got = 1'b1;
            if (ifc.Stall !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (ifc.Stall !== 1'b1) stall_ok = 1'b0;
         if (perturb && i == 10) begin
            ifc.SrcA = ~a; ifc.SrcB = 32'h8000_0003; ifc.Signed = ~sg;
         end
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("stall_window", 64'(stall_ok), 64'd1);
      @(posedge clk); #1;
      if (!keep) begin
         ifc.Start = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      cyc = 0; tests = 0; fails = 0;
      reset = 1'b0;
      ifc.Start = 1'b0; ifc.Signed = 1'b0; ifc.Long = 1'b0; ifc.SrcA = '0; ifc.SrcB = '0;

      fork
         forever begin
            @(negedge clk);
            if (ifc.Done === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 64'd1, 64'd0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("result_lo", 64'(ifc.ResultLo), 64'(e.lo));
                  chk("result_hi", 64'(ifc.ResultHi), 64'(e.hi));
                  chk("mul_flags", 64'(ifc.MulFlags), 64'(e.fl));
                  chk("latency",   64'(cyc - e.cyc), 64'(LAT));
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("rst_stall", 64'(ifc.Stall), 64'd0);
      chk("rst_busy",  64'(ifc.Busy),  64'd0);
      chk("rst_done",  64'(ifc.Done),  64'd0);
      chk("rst_res",   {ifc.ResultHi, ifc.ResultLo}, 64'd0);
      chk("rst_flags", 64'(ifc.MulFlags), 64'd0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("idle_stall", 64'(ifc.Stall), 64'd0);
      chk("idle_busy",  64'(ifc.Busy),  64'd0);
      chk("idle_res",   {ifc.ResultHi, ifc.ResultLo}, 64'd0);
      @(posedge clk); #1;

      // MUL 7*6
      mul(0, 0, 32'd7, 32'd6, 32'h0, 32'd42, 2'b00, 0, 0);
      // UMULL all-ones squared
      mul(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10, 0, 0);
      // SMULL -3*5
      mul(1, 1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2'b10, 0, 0);
      // SMULL most-negative squared
      mul(1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2'b00, 0, 0);
      // SMULL -7*-6
      mul(1, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0, 32'd42, 2'b00, 0, 0);
      // UMULL zero operand
      mul(0, 1, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 2'b01, 0, 0);
      // MUL overflowing into the high word: low word zero
      mul(0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 2'b01, 0, 0);
      // MUL with low-word MSB set
      mul(0, 0, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h8000_0000, 2'b10, 0, 0);
      // UMULL with operand perturbation mid-RUN
      mul(0, 1, 32'h0001_0001, 32'h0001_0001, 32'h0000_0001, 32'h0002_0001, 2'b00, 1, 0);
      // Back-to-back: Start held through DONE, next op accepted in following IDLE
      mul(0, 0, 32'd3, 32'd5, 32'h0, 32'd15, 2'b00, 0, 1);
      mul(1, 1, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b10, 0, 0);

      // Reset during RUN: abort, no Done, clean restart
      ifc.Start = 1'b1; ifc.Signed = 1'b0; ifc.Long = 1'b1;
      ifc.SrcA = 32'd9; ifc.SrcB = 32'd9;
      repeat (11) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy",  64'(ifc.Busy),  64'd0);
      chk("abort_stall", 64'(ifc.Stall), 64'd0);
      chk("abort_done",  64'(ifc.Done),  64'd0);
      ifc.Start = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      mul(0, 1, 32'd9, 32'd9, 32'h0, 32'd81, 2'b00, 0, 0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
